// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - 4-digit multiplexed seven-segment scan driver
// Frame-synchronous shadow load, free-running blink phase, active-low outputs.
module seg7_scan_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits,
  input  logic [3:0]  blank_mask,
  input  logic [3:0]  blink_mask,
  input  logic [3:0]  dp,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp_out
);

  localparam int RW = $clog2(REFRESH_DIV);
  localparam int BW = $clog2(BLINK_DIV);

  logic [RW-1:0] ref_q, ref_d;
  logic [1:0]    idx_q, idx_d;
  logic [BW-1:0] blk_q, blk_d;
  logic          phase_q, phase_d;
  logic [15:0]   sh_digits_q;
  logic [3:0]    sh_blank_q, sh_blink_q, sh_dp_q;
  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_out_q, dp_out_d;

  logic          tick, btick, frame_load, off;
  logic [3:0]    nib;
  logic [6:0]    dec;

  always_comb begin
    tick       = (ref_q == RW'(REFRESH_DIV - 1));
    btick      = (blk_q == BW'(BLINK_DIV - 1));
    frame_load = tick && (idx_q == 2'd3);
    ref_d      = tick ? '0 : ref_q + 1'b1;
    idx_d      = tick ? idx_q + 2'd1 : idx_q;
    blk_d      = btick ? '0 : blk_q + 1'b1;
    phase_d    = btick ? ~phase_q : phase_q;
  end

  always_comb begin
    nib = sh_digits_q[{idx_q, 2'b00} +: 4];
    off = sh_blank_q[idx_q] | (sh_blink_q[idx_q] & phase_q);
    case (nib)
      4'h0:    dec = 7'b1000000;
      4'h1:    dec = 7'b1111001;
      4'h2:    dec = 7'b0100100;
      4'h3:    dec = 7'b0110000;
      4'h4:    dec = 7'b0011001;
      4'h5:    dec = 7'b0010010;
      4'h6:    dec = 7'b0000010;
      4'h7:    dec = 7'b1111000;
      4'h8:    dec = 7'b0000000;
      4'h9:    dec = 7'b0010000;
      4'hA:    dec = 7'b0001000;
      4'hB:    dec = 7'b0000011;
      4'hC:    dec = 7'b1000110;
      4'hD:    dec = 7'b0100001;
      4'hE:    dec = 7'b0000110;
      default: dec = 7'b0001110;
    endcase
    an_d     = off ? 4'b1111 : ~(4'b0001 << idx_q);
    seg_d    = off ? 7'b1111111 : dec;
    dp_out_d = off ? 1'b1 : ~sh_dp_q[idx_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ref_q       <= '0;
      idx_q       <= '0;
      blk_q       <= '0;
      phase_q     <= 1'b0;
      sh_digits_q <= '0;
      sh_blank_q  <= '0;
      sh_blink_q  <= '0;
      sh_dp_q     <= '0;
      an_q        <= 4'b1111;
      seg_q       <= 7'b1111111;
      dp_out_q    <= 1'b1;
    end else begin
      ref_q    <= ref_d;
      idx_q    <= idx_d;
      blk_q    <= blk_d;
      phase_q  <= phase_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
      dp_out_q <= dp_out_d;
      // Shadows change only as the scan wraps to digit 0, so a frame never mixes data.
      if (frame_load) begin
        sh_digits_q <= digits;
        sh_blank_q  <= blank_mask;
        sh_blink_q  <= blink_mask;
        sh_dp_q     <= dp;
      end
    end
  end

  assign an     = an_q;
  assign seg    = seg_q;
  assign dp_out = dp_out_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver
// Reference model derives digit slot, frame and blink phase from elapsed cycles.
module tb_seg7_scan_driver;

  localparam int R = 4;
  localparam int B = 32;

  logic        clk;
  logic        rst;
  logic [15:0] digits;
  logic [3:0]  blank_mask, blink_mask, dp;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp_out;

  int checks = 0;
  int errors = 0;

  // Model state: k = cycles since reset release, shadows as the display should see them.
  int          k;
  logic [15:0] m_dig;
  logic [3:0]  m_blank, m_blink, m_dp;
  logic [3:0]  m_an;
  logic [6:0]  m_seg;
  logic        m_dpo;
  int          m_idx;
  int          m_frame;
  logic [6:0]  font [16];

  seg7_scan_driver #(.REFRESH_DIV(R), .BLINK_DIV(B)) dut (
    .clk(clk), .rst(rst), .digits(digits), .blank_mask(blank_mask),
    .blink_mask(blink_mask), .dp(dp), .an(an), .seg(seg), .dp_out(dp_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    logic [15:0] d_in;
    logic [3:0]  bl_in, bk_in, dp_in;
    logic        r_in;
    int          ph;
    logic        off;
    d_in = digits; bl_in = blank_mask; bk_in = blink_mask; dp_in = dp; r_in = rst;
    @(posedge clk);
    #1;
    if (r_in) begin
      k = 0; m_dig = '0; m_blank = '0; m_blink = '0; m_dp = '0;
      m_an = 4'b1111; m_seg = 7'b1111111; m_dpo = 1'b1; m_idx = -1; m_frame = 0;
    end else begin
      m_idx   = (k / R) % 4;
      m_frame = k / (4 * R);
      ph      = (k / B) % 2;
      off     = m_blank[m_idx] || (m_blink[m_idx] && ph == 1);
      m_an    = 4'b1111;
      if (!off) m_an[m_idx] = 1'b0;
      m_seg   = off ? 7'b1111111 : font[(m_dig >> (4 * m_idx)) & 16'hF];
      m_dpo   = off ? 1'b1 : !m_dp[m_idx];
      if (k % (4 * R) == 4 * R - 1) begin
        m_dig = d_in; m_blank = bl_in; m_blink = bk_in; m_dp = dp_in;
      end
      k++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin
      step();
      checks++;
      if ({an, seg, dp_out} !== {4'b1111, 7'b1111111, 1'b1}) begin
        errors++;
        $display("FAIL reset got an=%b seg=%b dp=%b want an=1111 seg=1111111 dp=1", an, seg, dp_out);
      end
    end
    rst = 1'b0;
    step();
    checks++;
    if ({an, seg, dp_out} !== {4'b1110, 7'b1000000, 1'b1}) begin
      errors++;
      $display("FAIL reset_release got an=%b seg=%b dp=%b want an=1110 seg=1000000 dp=1", an, seg, dp_out);
    end
  endtask

  task automatic test_scan();
    logic [3:0] order [4];
    order[0] = 4'b1110; order[1] = 4'b1101; order[2] = 4'b1011; order[3] = 4'b0111;
    for (int i = 1; i < 36; i++) begin
      step();
      checks++;
      if (an !== order[(i / R) % 4] || seg !== 7'b1000000 || an !== m_an) begin
        errors++;
        $display("FAIL scan i=%0d got an=%b seg=%b want an=%b seg=1000000", i, an, seg, order[(i / R) % 4]);
      end
    end
  endtask

  task automatic test_frame_sync();
    int guard = 0;
    int load_frame;
    while (!(m_idx == 1) && guard < 64) begin step(); guard++; end
    checks++;
    if (m_idx != 1) begin
      errors++;
      $display("FAIL frame_sync_wait got idx=%0d want 1", m_idx);
    end
    digits = 16'h1234;
    load_frame = m_frame + 1;
    for (int i = 0; i < 8 * R; i++) begin
      step();
      checks++;
      if ({an, seg, dp_out} !== {m_an, m_seg, m_dpo}) begin
        errors++;
        $display("FAIL frame_sync k=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", k, an, seg, dp_out, m_an, m_seg, m_dpo);
      end
      if (m_frame < load_frame) begin
        checks++;
        if (seg !== 7'b1000000) begin
          errors++;
          $display("FAIL frame_sync_old got seg=%b want 1000000", seg);
        end
      end else if (an == 4'b1110 || an == 4'b0111) begin
        checks++;
        if (seg !== (an == 4'b1110 ? 7'b0011001 : 7'b1111001)) begin
          errors++;
          $display("FAIL frame_sync_new an=%b got seg=%b", an, seg);
        end
      end
    end
  endtask

  task automatic test_blank_dp();
    blank_mask = 4'b0010; dp = 4'b0100;
    for (int i = 0; i < 12 * R; i++) begin
      step();
      checks++;
      if ({an, seg, dp_out} !== {m_an, m_seg, m_dpo}) begin
        errors++;
        $display("FAIL blank_dp k=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", k, an, seg, dp_out, m_an, m_seg, m_dpo);
      end
      if (m_frame > 0 && m_blank == 4'b0010 && m_idx == 1) begin
        checks++;
        if ({an, seg} !== {4'b1111, 7'b1111111}) begin
          errors++;
          $display("FAIL blank_slot got an=%b seg=%b want an=1111 seg=1111111", an, seg);
        end
      end
      if (m_dp == 4'b0100 && m_idx == 2) begin
        checks++;
        if (an !== 4'b1011 || dp_out !== 1'b0) begin
          errors++;
          $display("FAIL dp_slot got an=%b dp=%b want an=1011 dp=0", an, dp_out);
        end
      end
    end
    blank_mask = 4'b0000; dp = 4'b0000;
  endtask

  task automatic test_blink();
    int seen_on = 0;
    int seen_off = 0;
    blink_mask = 4'b0001; digits = 16'h0008;
    for (int i = 0; i < 6 * B; i++) begin
      step();
      checks++;
      if ({an, seg, dp_out} !== {m_an, m_seg, m_dpo}) begin
        errors++;
        $display("FAIL blink k=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", k, an, seg, dp_out, m_an, m_seg, m_dpo);
      end
      if (m_blink == 4'b0001 && m_dig == 16'h0008 && m_idx == 0) begin
        if (an == 4'b1111) seen_off++;
        if (an == 4'b1110 && seg == 7'b0000000) seen_on++;
      end
    end
    checks++;
    if (seen_on == 0 || seen_off == 0) begin
      errors++;
      $display("FAIL blink_alternate got on=%0d off=%0d want both nonzero", seen_on, seen_off);
    end
    blink_mask = 4'b0000;
  endtask

  task automatic test_reset_mid();
    int guard = 0;
    digits = 16'hABCD;
    while (!(m_dig == 16'hABCD && m_idx == 2) && guard < 200) begin step(); guard++; end
    checks++;
    if (an !== 4'b1011 || seg !== font[4'hB]) begin
      errors++;
      $display("FAIL reset_mid_pre got an=%b seg=%b want an=1011 seg=%b", an, seg, font[4'hB]);
    end
    rst = 1'b1;
    step();
    checks++;
    if ({an, seg, dp_out} !== {4'b1111, 7'b1111111, 1'b1}) begin
      errors++;
      $display("FAIL reset_mid got an=%b seg=%b dp=%b want an=1111 seg=1111111 dp=1", an, seg, dp_out);
    end
    rst = 1'b0;
    for (int i = 0; i < 6 * R; i++) begin
      step();
      checks++;
      if ({an, seg, dp_out} !== {m_an, m_seg, m_dpo} || (m_frame == 0 && seg !== 7'b1000000)) begin
        errors++;
        $display("FAIL reset_mid_after k=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", k, an, seg, dp_out, m_an, m_seg, m_dpo);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 5) == 0) begin
        digits     = 16'($urandom);
        blank_mask = 4'($urandom);
        blink_mask = 4'($urandom);
        dp         = 4'($urandom);
      end
      step();
      checks++;
      if ({an, seg, dp_out} !== {m_an, m_seg, m_dpo} || $countones(~an) > 1) begin
        errors++;
        $display("FAIL random k=%0d got an=%b seg=%b dp=%b want an=%b seg=%b dp=%b", k, an, seg, dp_out, m_an, m_seg, m_dpo);
      end
    end
  endtask

  initial begin
    font[0]  = 7'b1000000; font[1]  = 7'b1111001; font[2]  = 7'b0100100; font[3]  = 7'b0110000;
    font[4]  = 7'b0011001; font[5]  = 7'b0010010; font[6]  = 7'b0000010; font[7]  = 7'b1111000;
    font[8]  = 7'b0000000; font[9]  = 7'b0010000; font[10] = 7'b0001000; font[11] = 7'b0000011;
    font[12] = 7'b1000110; font[13] = 7'b0100001; font[14] = 7'b0000110; font[15] = 7'b0001110;
    rst = 1'b1; digits = '0; blank_mask = '0; blink_mask = '0; dp = '0;
    k = 0; m_dig = '0; m_blank = '0; m_blink = '0; m_dp = '0;
    m_an = 4'b1111; m_seg = 7'b1111111; m_dpo = 1'b1; m_idx = -1; m_frame = 0;
    test_reset();
    test_scan();
    test_frame_sync();
    test_blank_dp();
    test_blink();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
